// File: rtl/mac_kbd_host_if.sv
// Host-side bundle for the Macintosh keyboard host: command/response
// handshake plus the keyboard clock/data wire view.
interface mac_kbd_host_if;
  logic [7:0] cmd_data;
  logic       cmd_strobe;
  logic       busy;
  logic [7:0] resp_data;
  logic       resp_strobe;
  logic       timeout;
  logic       kbd_clk_i;
  logic       kbd_data_i;
  logic       kbd_data_o;

  modport master (
    output cmd_data, cmd_strobe, kbd_clk_i, kbd_data_i,
    input  busy, resp_data, resp_strobe, timeout, kbd_data_o
  );

  modport slave (
    input  cmd_data, cmd_strobe, kbd_clk_i, kbd_data_i,
    output busy, resp_data, resp_strobe, timeout, kbd_data_o
  );
endinterface

// File: rtl/mac_kbd_host.sv
// Macintosh keyboard host: sends one command byte, receives one response byte.
// Optional kbd clock glitch filter enabled by MAC_KBD_HOST_CLK_FILTER_EN.
module mac_kbd_host #(
  parameter int unsigned TIMEOUT     = 2000000,
  parameter int unsigned BIT_TIMEOUT = 4000,
  parameter int unsigned TURN_HOLD   = 400
) (
  input  logic         clk32,
  input  logic         _reset,
  input  logic         clk8_en_p,
  mac_kbd_host_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, TX, TURN, RX, DONE} state_t;

  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic        kclk, kclk_prev_q, fall, rise;
  logic [7:0]  sh_q, sh_d, resp_q, resp_d;
  logic [2:0]  bit_q, bit_d;
  logic [20:0] tmo_q, tmo_d;
  logic        seen_q, seen_d;
  logic        dout_q, dout_d;
  logic        abort;

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else if (clk8_en_p) begin
      clk_s1_q <= bus.kbd_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= bus.kbd_data_i;
      dat_s2_q <= dat_s1_q;
    end
  end

`ifdef MAC_KBD_HOST_CLK_FILTER_EN
  logic [2:0] hist_q;
  logic       filt_q;

  // New level passes combinationally once it plus three prior samples agree.
  assign kclk = (hist_q == {3{clk_s2_q}}) ? clk_s2_q : filt_q;

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else if (clk8_en_p) begin
      hist_q <= {hist_q[1:0], clk_s2_q};
      filt_q <= kclk;
    end
  end
`else
  assign kclk = clk_s2_q;
`endif

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) kclk_prev_q <= 1'b1;
    else if (clk8_en_p) kclk_prev_q <= kclk;
  end

  assign fall = kclk_prev_q & ~kclk;
  assign rise = ~kclk_prev_q & kclk;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    resp_d  = resp_q;
    bit_d   = bit_q;
    seen_d  = seen_q;
    dout_d  = dout_q;
    tmo_d   = tmo_q;
    abort   = 1'b0;
    if (clk8_en_p) begin
      tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 21'd1;
      unique case (state_q)
        IDLE: begin
          dout_d = 1'b1;
          if (bus.cmd_strobe) begin
            sh_d    = bus.cmd_data;
            bit_d   = '0;
            dout_d  = 1'b0;
            state_d = REQ;
          end
        end
        REQ: begin
          if (fall) begin
            dout_d  = sh_q[7];
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = TX;
          end
        end
        TX: begin
          if (fall) begin
            dout_d = sh_q[7];
            sh_d   = {sh_q[6:0], 1'b0};
          end
          if (rise) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              dout_d  = 1'b0;
              state_d = TURN;
            end
          end
          if (fall || rise) tmo_d = '0;
          else if (tmo_q == 21'(BIT_TIMEOUT - 1)) abort = 1'b1;
        end
        TURN: begin
          if (tmo_q == 21'(TURN_HOLD - 1)) begin
            dout_d  = 1'b1;
            bit_d   = '0;
            seen_d  = 1'b0;
            state_d = RX;
          end
        end
        RX: begin
          if (rise) begin
            sh_d  = {sh_q[6:0], dat_s2_q};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              resp_d  = {sh_q[6:0], dat_s2_q};
              state_d = DONE;
            end
          end
          // The first edge gets the long response window, later ones the bit window.
          if (fall || rise) begin
            tmo_d  = '0;
            seen_d = 1'b1;
          end else if (seen_q ? (tmo_q == 21'(BIT_TIMEOUT - 1))
                              : (tmo_q == 21'(TIMEOUT - 1))) begin
            abort = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (abort) begin
        dout_d  = 1'b1;
        state_d = IDLE;
      end
      if (state_d != state_q) tmo_d = '0;
    end
  end

  always_ff @(posedge clk32 or negedge _reset) begin
    if (!_reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      resp_q  <= '0;
      bit_q   <= '0;
      seen_q  <= 1'b0;
      dout_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      resp_q  <= resp_d;
      bit_q   <= bit_d;
      seen_q  <= seen_d;
      dout_q  <= dout_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.resp_data   = resp_q;
  assign bus.resp_strobe = clk8_en_p && (state_q == DONE);
  assign bus.timeout     = abort;
  assign bus.kbd_data_o  = dout_q;

endmodule

// File: tb/tb_mac_kbd_host.sv
// Scoreboard bench for mac_kbd_host with a behavioural keyboard model.
module tb_mac_kbd_host;
  localparam int unsigned TO   = 200;
  localparam int unsigned BT   = 40;
  localparam int unsigned TH   = 20;
  localparam int unsigned HALF = 12;
`ifdef MAC_KBD_HOST_CLK_FILTER_EN
  localparam int unsigned FILT = 3;
`else
  localparam int unsigned FILT = 0;
`endif

  logic clk32 = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic kb_clk  = 1'b1;
  logic kb_data = 1'b1;
  int   rx_idx  = -1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mac_kbd_host_if bus();
  assign bus.kbd_clk_i  = kb_clk;
  assign bus.kbd_data_i = bus.kbd_data_o & kb_data;

  mac_kbd_host #(.TIMEOUT(TO), .BIT_TIMEOUT(BT), .TURN_HOLD(TH)) dut (
    .clk32(clk32), ._reset(rst_n), .clk8_en_p(en), .bus(bus)
  );

  always #5 clk32 = ~clk32;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk32);
      #1;
      ph = (ph + 1) % 4;
      en = (ph == 0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit          is_tmo;
    logic [7:0]  data;
    bit          from_clk;
    int unsigned ticks;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: tick counters since last data release / last kbd clock change.
  initial begin
    int unsigned ctr_do, ctr_clk;
    logic prev_do, prev_clk;
    exp_t e;
    ctr_do = 0; ctr_clk = 0; prev_do = 1'b1; prev_clk = 1'b1;
    forever begin
      @(negedge clk32);
      if (bus.kbd_data_o && !prev_do) ctr_do = 0;
      if (kb_clk != prev_clk) ctr_clk = 0;
      prev_do  = bus.kbd_data_o;
      prev_clk = kb_clk;
      if (en) begin
        ctr_do++;
        ctr_clk++;
      end
      if (bus.resp_strobe || bus.timeout) begin
        check("event_expected", int'(sb_q.size() != 0), 1);
        check("no_double_pulse", int'(bus.resp_strobe & bus.timeout), 0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("event_kind", int'(bus.timeout), int'(e.is_tmo));
          if (e.is_tmo)
            check(e.from_clk ? "bit_tmo_ticks" : "rx_tmo_ticks",
                  e.from_clk ? ctr_clk : ctr_do, e.ticks);
          else
            check("resp_data", int'(bus.resp_data), int'(e.data));
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      do @(posedge clk32); while (!en);
      #2;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    tick(1);
    bus.cmd_data   = b;
    bus.cmd_strobe = 1'b1;
    tick(1);
    bus.cmd_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max_ticks);
    int unsigned w;
    w = 0;
    while (bus.busy && w < max_ticks) begin
      tick(1);
      w++;
    end
    check("idle_reached", int'(bus.busy), 0);
  endtask

  task automatic kb_txn(input logic [7:0] resp, input int unsigned tx_bits,
                        input bit do_rx, input bit glitch,
                        input logic [7:0] exp_cmd, input bit chk_cmd);
    logic [7:0] rcv;
    int unsigned w;
    rcv = '0;
    rx_idx = -1;
    w = 0;
    while (bus.kbd_data_i && w < 400) begin
      tick(1);
      w++;
    end
    check("kb_req_seen", int'(bus.kbd_data_i), 0);
    if (bus.kbd_data_i) return;
    tick(5);
    for (int unsigned i = 0; i < tx_bits; i++) begin
      kb_clk = 1'b0;
      if (glitch && i == 3) begin
        tick(8); kb_clk = 1'b1; tick(2); kb_clk = 1'b0; tick(8);
      end else begin
        tick(HALF);
      end
      rcv = {rcv[6:0], bus.kbd_data_i};
      kb_clk = 1'b1;
      tick(HALF);
    end
    if (chk_cmd) check("kb_cmd", int'(rcv), int'(exp_cmd));
    if (do_rx) begin
      w = 0;
      while (!bus.kbd_data_i && w < 400) begin
        tick(1);
        w++;
      end
      check("kb_turn_release", int'(bus.kbd_data_i), 1);
      tick(6);
      for (int unsigned i = 0; i < 8; i++) begin
        kb_data = resp[3'(7 - i)];
        rx_idx  = int'(i);
        kb_clk  = 1'b0;
        tick(HALF);
        kb_clk  = 1'b1;
        tick(HALF);
      end
      kb_data = 1'b1;
      rx_idx  = 8;
    end
  endtask

  initial begin
    int unsigned restarted, w;
    bus.cmd_data   = '0;
    bus.cmd_strobe = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk32);
    check("rst_busy",        int'(bus.busy), 0);
    check("rst_kbd_data_o",  int'(bus.kbd_data_o), 1);
    check("rst_resp_data",   int'(bus.resp_data), 0);
    check("rst_resp_strobe", int'(bus.resp_strobe), 0);
    check("rst_timeout",     int'(bus.timeout), 0);
    #3 rst_n = 1'b1;
    tick(3);

    // Normal exchange
    sb_q.push_back('{is_tmo: 1'b0, data: 8'h7B, from_clk: 1'b0, ticks: 0});
    fork
      kb_txn(8'h7B, 8, 1'b1, 1'b0, 8'h10, 1'b1);
      send_cmd(8'h10);
    join
    wait_idle(50);
    tick(5);

    sb_q.push_back('{is_tmo: 1'b0, data: 8'h3C, from_clk: 1'b0, ticks: 0});
    fork
      kb_txn(8'h3C, 8, 1'b1, 1'b0, 8'hA5, 1'b1);
      send_cmd(8'hA5);
    join
    wait_idle(50);
    tick(5);

    // Keyboard never answers
    sb_q.push_back('{is_tmo: 1'b1, data: 8'h00, from_clk: 1'b0, ticks: TO});
    fork
      kb_txn(8'h00, 8, 1'b0, 1'b0, 8'h36, 1'b1);
      send_cmd(8'h36);
    join
    wait_idle(TO + 50);
    check("rx_tmo_release", int'(bus.kbd_data_o), 1);
    tick(5);

    // Keyboard stops after three command bits
    sb_q.push_back('{is_tmo: 1'b1, data: 8'h00, from_clk: 1'b1, ticks: BT + 3 + FILT});
    fork
      kb_txn(8'h00, 3, 1'b0, 1'b0, 8'h00, 1'b0);
      send_cmd(8'hC3);
    join
    wait_idle(BT + 50);
    check("bit_tmo_release", int'(bus.kbd_data_o), 1);
    tick(5);

    // Strobe while busy is dropped
    sb_q.push_back('{is_tmo: 1'b0, data: 8'h81, from_clk: 1'b0, ticks: 0});
    fork
      kb_txn(8'h81, 8, 1'b1, 1'b0, 8'h16, 1'b1);
      begin
        send_cmd(8'h16);
        tick(60);
        send_cmd(8'h14);
      end
    join
    wait_idle(50);
    restarted = 0;
    repeat (60) begin
      tick(1);
      if (bus.busy || !bus.kbd_data_o) restarted++;
    end
    check("no_queued_cmd", restarted, 0);

    // Reset in the middle of the response
    fork
      kb_txn(8'h99, 8, 1'b1, 1'b0, 8'h22, 1'b1);
      begin
        send_cmd(8'h22);
        w = 0;
        while (rx_idx != 4 && w < 20000) begin
          @(negedge clk32);
          w++;
        end
        check("reached_rx_bit4", rx_idx, 4);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_kbd_data_o", int'(bus.kbd_data_o), 1);
        check("rst_mid_busy",       int'(bus.busy), 0);
        check("rst_mid_resp_data",  int'(bus.resp_data), 0);
        tick(2);
        rst_n = 1'b1;
      end
    join
    tick(30);
    check("resp_after_reset", int'(bus.resp_data), 0);

`ifdef MAC_KBD_HOST_CLK_FILTER_EN
    // Short clock glitches during the command
    sb_q.push_back('{is_tmo: 1'b0, data: 8'h6E, from_clk: 1'b0, ticks: 0});
    fork
      kb_txn(8'h6E, 8, 1'b1, 1'b1, 8'h4C, 1'b1);
      send_cmd(8'h4C);
    join
    wait_idle(50);
`endif

    tick(10);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
